// File: rtl/byte_enable_dp_ram_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM.
package byte_enable_dp_ram_pkg;

    // Post-reset clear engine states.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_e;

    // Number of 8-bit lanes in a word.
    function automatic int unsigned byte_lanes(input int unsigned dw);
        return dw / 8;
    endfunction

endpackage

// Elaboration-time legality check; label names the generate block.
`define BEDP_ELAB_CHECK(label, cond, msg) \
    if (!(cond)) begin : label \
        $error(msg); \
    end

// File: rtl/byte_enable_ram_port.sv
// Per-port lane write enables, read-during-write mux and output pipeline.
module byte_enable_ram_port
    import byte_enable_dp_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int          WRITE_FIRST = 1,
    parameter int          OUTPUT_REG  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    accept,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH-1:0]   rd_word,
    output logic [DATA_WIDTH/8-1:0] lane_we,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid
);

    localparam int unsigned NL = byte_lanes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] rd_next;
    logic [DATA_WIDTH-1:0] s1_q;
    logic                  s1_v;

    for (genvar l = 0; l < NL; l++) begin : g_lane
        assign lane_we[l] = accept & be[l];
        assign rd_next[l*8 +: 8] = ((WRITE_FIRST != 0) && be[l]) ? data_in[l*8 +: 8]
                                                                  : rd_word[l*8 +: 8];
    end

    // Stage-1 read register: loads on accepted access, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s1_v <= 1'b0;
        end else begin
            s1_v <= accept;
            if (accept) begin
                s1_q <= rd_next;
            end
        end
    end

    if (OUTPUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] s2_q;
        logic                  s2_v;

        // Optional second stage: only advances on a valid result so data holds.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_q <= '0;
                s2_v <= 1'b0;
            end else begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_q <= s1_q;
                end
            end
        end

        assign data_out = s2_q;
        assign valid    = s2_v;
    end else begin : g_noreg
        assign data_out = s1_q;
        assign valid    = s1_v;
    end

endmodule

// File: rtl/byte_enable_dp_ram.sv
// True-dual-port byte-enable RAM with clear engine and collision handling.
module byte_enable_dp_ram
  import byte_enable_dp_ram_pkg::*;
#(
  parameter int unsigned LINES            = 4096,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int          WRITE_FIRST      = 1,
  parameter int          OUTPUT_REG       = 0,
  parameter int          CLEAR_ON_RESET   = 0,
  parameter int          USE_PRELOAD_FILE = 0,
  parameter string       PRELOAD_FILE     = ""
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(LINES)-1:0] addr_a,
  input  logic                     en_a,
  input  logic [DATA_WIDTH/8-1:0]  be_a,
  input  logic [DATA_WIDTH-1:0]    data_in_a,
  output logic [DATA_WIDTH-1:0]    data_out_a,
  output logic                     valid_a,
  input  logic [$clog2(LINES)-1:0] addr_b,
  input  logic                     en_b,
  input  logic [DATA_WIDTH/8-1:0]  be_b,
  input  logic [DATA_WIDTH-1:0]    data_in_b,
  output logic [DATA_WIDTH-1:0]    data_out_b,
  output logic                     valid_b,
  output logic                     ready,
  output logic                     collision
);

  localparam int unsigned AW = $clog2(LINES);
  localparam int unsigned NL = byte_lanes(DATA_WIDTH);

  `BEDP_ELAB_CHECK(g_chk_lines, (LINES >= 2) && ((LINES & (LINES - 1)) == 0),
                   "LINES must be a power of two and at least 2")
  `BEDP_ELAB_CHECK(g_chk_width, (DATA_WIDTH >= 8) && ((DATA_WIDTH % 8) == 0),
                   "DATA_WIDTH must be a non-zero multiple of 8")
  `BEDP_ELAB_CHECK(g_chk_init, !((CLEAR_ON_RESET != 0) && (USE_PRELOAD_FILE != 0)),
                   "CLEAR_ON_RESET and USE_PRELOAD_FILE are mutually exclusive")

  logic [DATA_WIDTH-1:0] mem [LINES];

  clr_state_e            state;
  clr_state_e            state_nx;
  logic [AW-1:0]         clr_addr;
  logic                  acc_a;
  logic                  acc_b;
  logic                  same_addr;
  logic                  collision_nx;
  logic [NL-1:0]         we_a;
  logic [NL-1:0]         we_b_raw;
  logic [NL-1:0]         we_b;
  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;

  assign ready = (state == ST_READY);
  assign acc_a = en_a & ready;
  assign acc_b = en_b & ready;
  assign rd_a  = mem[addr_a];
  assign rd_b  = mem[addr_b];

  // Port A owns every overlapping byte; port B keeps only its disjoint lanes.
  always_comb begin
    same_addr    = (addr_a == addr_b);
    we_b         = we_b_raw & ~(we_a & {NL{same_addr}});
    collision_nx = same_addr & (|(we_a & we_b_raw));
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_CLEAR: if (clr_addr == AW'(LINES - 1)) state_nx = ST_READY;
      ST_READY: state_nx = ST_READY;
      default:  state_nx = ST_READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_addr  <= '0;
      collision <= 1'b0;
    end else begin
      state     <= state_nx;
      collision <= collision_nx;
      if (state == ST_CLEAR) begin
        clr_addr <= clr_addr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int unsigned l = 0; l < NL; l++) begin
        if (we_a[l]) mem[addr_a][l*8 +: 8] <= data_in_a[l*8 +: 8];
        if (we_b[l]) mem[addr_b][l*8 +: 8] <= data_in_b[l*8 +: 8];
      end
    end
  end

  byte_enable_ram_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .WRITE_FIRST(WRITE_FIRST),
    .OUTPUT_REG (OUTPUT_REG)
  ) u_port_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .accept  (acc_a),
    .be      (be_a),
    .data_in (data_in_a),
    .rd_word (rd_a),
    .lane_we (we_a),
    .data_out(data_out_a),
    .valid   (valid_a)
  );

  byte_enable_ram_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .WRITE_FIRST(WRITE_FIRST),
    .OUTPUT_REG (OUTPUT_REG)
  ) u_port_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .accept  (acc_b),
    .be      (be_b),
    .data_in (data_in_b),
    .rd_word (rd_b),
    .lane_we (we_b_raw),
    .data_out(data_out_b),
    .valid   (valid_b)
  );

endmodule

// File: tb/tb_byte_enable_dp_ram.sv
// Bench: two RAM configurations driven with shared stimulus and checked
// against a per-configuration reference model plus directed vector table.
module tb_byte_enable_dp_ram;

    // dut0: write-first, latency 1, clears on reset.
    // dut1: read-first, latency 2, no clear.
    localparam int LAT [2] = '{1, 2};
    localparam bit WF  [2] = '{1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  addr_a, addr_b;
    logic        en_a, en_b;
    logic [3:0]  be_a, be_b;
    logic [31:0] data_in_a, data_in_b;

    logic [31:0] dout [4];   // index = dut*2 + port
    logic        vout [4];
    logic        rdy_o [2];
    logic        col_o [2];

    always #5 clk = ~clk;

    byte_enable_dp_ram #(
        .LINES(16), .DATA_WIDTH(32), .WRITE_FIRST(1), .OUTPUT_REG(0),
        .CLEAR_ON_RESET(1), .USE_PRELOAD_FILE(0), .PRELOAD_FILE("")
    ) dut0 (
        .clk(clk), .rst_n(rst_n),
        .addr_a(addr_a), .en_a(en_a), .be_a(be_a), .data_in_a(data_in_a),
        .data_out_a(dout[0]), .valid_a(vout[0]),
        .addr_b(addr_b), .en_b(en_b), .be_b(be_b), .data_in_b(data_in_b),
        .data_out_b(dout[1]), .valid_b(vout[1]),
        .ready(rdy_o[0]), .collision(col_o[0])
    );

    byte_enable_dp_ram #(
        .LINES(16), .DATA_WIDTH(32), .WRITE_FIRST(0), .OUTPUT_REG(1),
        .CLEAR_ON_RESET(0), .USE_PRELOAD_FILE(0), .PRELOAD_FILE("")
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .addr_a(addr_a), .en_a(en_a), .be_a(be_a), .data_in_a(data_in_a),
        .data_out_a(dout[2]), .valid_a(vout[2]),
        .addr_b(addr_b), .en_b(en_b), .be_b(be_b), .data_in_b(data_in_b),
        .data_out_b(dout[3]), .valid_b(vout[3]),
        .ready(rdy_o[1]), .collision(col_o[1])
    );

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [31:0] d;
    } res_t;

    logic [31:0] m_mem [2][16];
    int          clr_left [2];
    logic        exp_col [2];
    logic [31:0] ed [4];
    res_t        q [4][$];
    int          cyc = 0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            exp_col[k] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                q[k*2+p].delete();
                ed[k*2+p] = '0;
            end
        end
        clr_left[0] = 16;
        clr_left[1] = 0;
        for (int i = 0; i < 16; i++) m_mem[0][i] = '0;
    endtask

    // Predict the effect of the inputs presented for the coming edge.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic        rdy, aa, ab;
            logic [31:0] oa, ob, ra, rb;
            rdy = (clr_left[k] == 0);
            aa  = en_a && rdy;
            ab  = en_b && rdy;
            oa  = m_mem[k][addr_a];
            ob  = m_mem[k][addr_b];
            for (int i = 0; i < 4; i++) begin
                ra[i*8 +: 8] = (WF[k] && be_a[i]) ? data_in_a[i*8 +: 8] : oa[i*8 +: 8];
                rb[i*8 +: 8] = (WF[k] && be_b[i]) ? data_in_b[i*8 +: 8] : ob[i*8 +: 8];
            end
            // B applied first, then A, so A wins any shared byte.
            for (int i = 0; i < 4; i++) begin
                if (ab && be_b[i]) m_mem[k][addr_b][i*8 +: 8] = data_in_b[i*8 +: 8];
            end
            for (int i = 0; i < 4; i++) begin
                if (aa && be_a[i]) m_mem[k][addr_a][i*8 +: 8] = data_in_a[i*8 +: 8];
            end
            exp_col[k] = aa && ab && (addr_a == addr_b) && ((be_a & be_b) != 4'h0);
            if (aa) q[k*2].push_back('{cyc + LAT[k], ra});
            if (ab) q[k*2+1].push_back('{cyc + LAT[k], rb});
            if (clr_left[k] > 0) clr_left[k]--;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("dut%0d ready", k), 32'(rdy_o[k]), 32'(clr_left[k] == 0));
            chk($sformatf("dut%0d collision", k), 32'(col_o[k]), 32'(exp_col[k]));
            for (int p = 0; p < 2; p++) begin
                int   idx;
                logic ev;
                idx = k*2 + p;
                ev  = 1'b0;
                if (q[idx].size() > 0 && q[idx][0].due == cyc) begin
                    ev      = 1'b1;
                    ed[idx] = q[idx][0].d;
                    void'(q[idx].pop_front());
                end
                chk($sformatf("dut%0d port%0d valid", k, p), 32'(vout[idx]), 32'(ev));
                chk($sformatf("dut%0d port%0d data", k, p), dout[idx], ed[idx]);
            end
        end
    endtask

    // One clock: called at a negedge with inputs already driven.
    task automatic cyc_run();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic idle();
        en_a = 1'b0; en_b = 1'b0; be_a = '0; be_b = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset data_out %0d", i), dout[i], 32'h0);
            chk($sformatf("reset valid %0d", i), 32'(vout[i]), 32'h0);
        end
        chk("reset collision 0", 32'(col_o[0]), 32'h0);
        chk("reset collision 1", 32'(col_o[1]), 32'h0);
        chk("reset ready 0", 32'(rdy_o[0]), 32'h0);
        chk("reset ready 1", 32'(rdy_o[1]), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed vectors (expectations for dut0, latency 1) ----------------
    typedef struct {
        logic        en_a;
        logic [3:0]  be_a;
        logic [3:0]  addr_a;
        logic [31:0] din_a;
        logic        en_b;
        logic [3:0]  be_b;
        logic [3:0]  addr_b;
        logic [31:0] din_b;
        logic        chk_a;
        logic [31:0] exp_a;
        logic        chk_b;
        logic [31:0] exp_b;
        logic        exp_col;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int cnt;
        logic [31:0] ob_exp [5];
        logic        ov_exp [5];

        tbl[0]  = '{1'b1, 4'hF, 4'd3, 32'h11223344, 1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 32'h11223344, 1'b0, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 4'h5, 4'd3, 32'hAABBCCDD, 1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 32'h11BB33DD, 1'b0, 32'h0,        1'b0};
        tbl[2]  = '{1'b1, 4'h0, 4'd3, 32'h0,        1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 32'h11BB33DD, 1'b0, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 4'hF, 4'd5, 32'h0,        1'b1, 4'hF, 4'd7, 32'h12345678, 1'b1, 32'h0,        1'b1, 32'h12345678, 1'b0};
        tbl[4]  = '{1'b1, 4'h3, 4'd5, 32'h000000AA, 1'b1, 4'h6, 4'd5, 32'h0000BB00, 1'b1, 32'h000000AA, 1'b1, 32'h0000BB00, 1'b1};
        tbl[5]  = '{1'b1, 4'h0, 4'd5, 32'h0,        1'b1, 4'h0, 4'd5, 32'h0,        1'b1, 32'h000000AA, 1'b1, 32'h000000AA, 1'b0};
        tbl[6]  = '{1'b1, 4'hF, 4'd7, 32'hDEADBEEF, 1'b1, 4'h0, 4'd7, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 32'h12345678, 1'b0};
        tbl[7]  = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'h0, 4'd7, 32'h0,        1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        tbl[8]  = '{1'b1, 4'h0, 4'd15, 32'h0,       1'b1, 4'h0, 4'd0, 32'h0,        1'b1, 32'hC0DE000F, 1'b1, 32'hC0DE0000, 1'b0};
        tbl[9]  = '{1'b1, 4'h8, 4'd9, 32'hFF000000, 1'b1, 4'h8, 4'd9, 32'h11000000, 1'b1, 32'hFFDE0009, 1'b1, 32'h11DE0009, 1'b1};
        tbl[10] = '{1'b1, 4'h0, 4'd9, 32'h0,        1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 32'hFFDE0009, 1'b0, 32'h0,        1'b0};

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++) m_mem[k][i] = '0;
        addr_a = '0; addr_b = '0; data_in_a = '0; data_in_b = '0;
        idle();

        #2;
        apply_reset();

        // Clear sweep: dut0 ignores these writes; dut1 stores them.
        cnt = 0;
        while (!rdy_o[0] && cnt < 40) begin
            en_a = 1'b1; be_a = 4'hF; addr_a = 4'(cnt); data_in_a = 32'hC0DE0000 | 32'(cnt);
            cyc_run();
            cnt++;
        end
        chk("clear sweep length", 32'(cnt), 32'd16);

        // Last line is zero right after the sweep.
        en_a = 1'b1; be_a = 4'h0; addr_a = 4'd15;
        cyc_run();
        chk("post-clear line15 data", dout[0], 32'h0);
        chk("post-clear line15 valid", 32'(vout[0]), 32'h1);

        // Load identical contents into both RAMs.
        for (int i = 0; i < 16; i++) begin
            en_a = 1'b1; be_a = 4'hF; addr_a = 4'(i); data_in_a = 32'hC0DE0000 | 32'(i);
            cyc_run();
        end
        idle();

        for (int t = 0; t < 11; t++) begin
            en_a = tbl[t].en_a; be_a = tbl[t].be_a; addr_a = tbl[t].addr_a; data_in_a = tbl[t].din_a;
            en_b = tbl[t].en_b; be_b = tbl[t].be_b; addr_b = tbl[t].addr_b; data_in_b = tbl[t].din_b;
            cyc_run();
            if (tbl[t].chk_a) chk($sformatf("vec%0d data_out_a", t), dout[0], tbl[t].exp_a);
            if (tbl[t].chk_b) chk($sformatf("vec%0d data_out_b", t), dout[1], tbl[t].exp_b);
            chk($sformatf("vec%0d collision", t), 32'(col_o[0]), 32'(tbl[t].exp_col));
        end
        idle();
        cyc_run();
        cyc_run();

        // Latency-2 back-to-back reads on port B of dut1.
        ob_exp = '{32'h0, 32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0002};
        ov_exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int s = 0; s < 5; s++) begin
            if (s < 3) begin
                en_b = 1'b1; be_b = 4'h0; addr_b = 4'(s);
            end else begin
                en_b = 1'b0;
            end
            cyc_run();
            chk($sformatf("oreg seq valid_b %0d", s), 32'(vout[3]), 32'(ov_exp[s]));
            if (s > 0) chk($sformatf("oreg seq data_b %0d", s), dout[3], ob_exp[s]);
        end
        idle();

        // Randomised traffic; narrow address range half the time to force overlaps.
        for (int r = 0; r < 300; r++) begin
            logic narrow;
            narrow    = 1'($urandom_range(0, 1));
            en_a      = 1'($urandom_range(0, 1));
            en_b      = 1'($urandom_range(0, 1));
            be_a      = 4'($urandom);
            be_b      = 4'($urandom);
            addr_a    = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom);
            addr_b    = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom);
            data_in_a = $urandom;
            data_in_b = $urandom;
            cyc_run();
        end
        idle();

        // Reset, then abort the sweep at clr_addr = 9 with dut1 busy reading.
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            en_b = 1'b1; be_b = 4'h0; addr_b = 4'd2;
            cyc_run();
        end
        idle();
        #2;
        apply_reset();

        cnt = 0;
        while (!rdy_o[0] && cnt < 40) begin
            idle();
            if (cnt == 10) begin
                en_a = 1'b1; be_a = 4'hF; addr_a = 4'd3; data_in_a = 32'h55555555;
            end
            cyc_run();
            cnt++;
        end
        chk("restarted sweep length", 32'(cnt), 32'd16);
        idle();

        en_a = 1'b1; be_a = 4'h0; addr_a = 4'd3;
        cyc_run();
        chk("write during clear dropped", dout[0], 32'h0);
        idle();
        cyc_run();
        cyc_run();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Hard stop if the run ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d checks done", n_chk);
        $fatal(1);
    end

endmodule
